// File: rtl/leading_bit_counter.sv
// leading_bit_counter
//   Multi-cycle count-leading-zeros / count-leading-ones unit for CLZ/CLO.
//   The operand is scanned from the MSB, STEP bits per cycle. Valid/ready
//   handshakes are used on both sides, and only one operand is in flight.
// Ports
//   clk, rst_n  rising-edge clock, asynchronous active-low reset
//   in_valid    operand offered
//   in_ready    unit idle and able to accept (registered)
//   in_data     WIDTH-bit operand, sampled only on the accept edge
//   in_ones     0 = count leading zeros, 1 = count leading ones
//   flush       synchronous abort of any operation in progress
//   out_valid   result valid, held until out_ready (registered)
//   out_ready   consumer accepts the result
//   out_count   leading-bit count, 0..WIDTH (registered)
//   out_all     out_count == WIDTH (registered)
module leading_bit_counter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 4,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_ones,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count,
    output logic             out_all
);

    localparam int unsigned NCHUNK = WIDTH / STEP;
    localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sh;
    logic [IDX_W-1:0] idx;
    logic [STEP-1:0]  chunk;
    logic [CNT_W-1:0] chunk_lz;
    logic             chunk_zero;

    // Top STEP bits of the shift register are the chunk under inspection.
    assign chunk      = sh[WIDTH-1 -: STEP];
    assign chunk_zero = (chunk == '0);

    // Priority encoder: leading zeros of the chunk (the highest set bit wins).
    always_comb begin
        chunk_lz = CNT_W'(STEP);
        for (int unsigned i = 0; i < STEP; i++) begin
            if (chunk[i]) begin
                chunk_lz = CNT_W'(STEP - 1 - i);
            end
        end
    end

    // FSM with registered handshake and result outputs.
    // out_valid rises one cycle after entering DONE, so the handshake is only
    // honoured once the consumer has actually seen out_valid high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_count <= '0;
            out_all   <= 1'b0;
            sh        <= '0;
            idx       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // flush outranks in_valid: nothing is accepted while flushing
                    if (!flush && in_valid) begin
                        sh        <= in_ones ? ~in_data : in_data;
                        out_count <= '0;
                        out_all   <= 1'b0;
                        idx       <= '0;
                        in_ready  <= 1'b0;
                        state     <= SCAN;
                    end
                end
                SCAN: begin
                    if (flush) begin
                        in_ready <= 1'b1;
                        state    <= IDLE;
                    end else if (!chunk_zero) begin
                        out_count <= out_count + chunk_lz;
                        state     <= DONE;
                    end else if (idx == LAST_IDX) begin
                        out_count <= CNT_W'(WIDTH);
                        out_all   <= 1'b1;
                        state     <= DONE;
                    end else begin
                        out_count <= out_count + CNT_W'(STEP);
                        sh        <= sh << STEP;
                        idx       <= idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (flush) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end else if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        out_valid <= 1'b1;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_leading_bit_counter.sv
// Bench for leading_bit_counter (WIDTH=32, STEP=4): directed vector table,
// hand-written hold / flush / reset sequences and a random model compare.
module tb_leading_bit_counter;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned STEP  = 4;
    localparam int unsigned CNT_W = 6;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_ones;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] out_count;
    logic             out_all;

    int checks = 0;
    int errors = 0;

    leading_bit_counter #(.WIDTH(WIDTH), .STEP(STEP), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_ones  (in_ones),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_count(out_count),
        .out_all  (out_all)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        ones;
        logic [5:0]  cnt;
        logic        all;
        int          lat;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Offer one operand and return after the accept edge (+1).
    task automatic offer(input logic [31:0] d, input logic ones);
        in_valid = 1'b1;
        in_data  = d;
        in_ones  = ones;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = $urandom;
        in_ones  = 1'($urandom);
    endtask

    // Count edges after the accept edge until out_valid is seen (bounded).
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_op(input logic [31:0] d, input logic ones, input logic [5:0] ec,
                          input logic ea, input int el, input string tag);
        int lat;
        check({tag, " in_ready idle"}, longint'(in_ready), 1);
        offer(d, ones);
        check({tag, " in_ready busy"}, longint'(in_ready), 0);
        wait_valid(lat);
        check({tag, " latency"}, longint'(lat), longint'(el));
        check({tag, " out_count"}, longint'(out_count), longint'(ec));
        check({tag, " out_all"}, longint'(out_all), longint'(ea));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, " out_valid drop"}, longint'(out_valid), 0);
        check({tag, " in_ready back"}, longint'(in_ready), 1);
    endtask

    function automatic int ref_count(input logic [31:0] d, input logic ones);
        logic [31:0] s;
        int n;
        s = ones ? ~d : d;
        n = 0;
        for (int i = 31; i >= 0; i--) begin
            if (s[i]) break;
            n++;
        end
        return n;
    endfunction

    function automatic int ref_lat(input int n);
        int k;
        k = (n == 32) ? 7 : n / 4;
        return k + 2;
    endfunction

    initial begin
        int lat;
        int n;
        logic [31:0] d;
        logic o;

        vecs[0]  = '{32'h0001_0000, 1'b0, 6'd15, 1'b0, 5};
        vecs[1]  = '{32'h8000_0000, 1'b0, 6'd0,  1'b0, 2};
        vecs[2]  = '{32'h0000_0000, 1'b0, 6'd32, 1'b1, 9};
        vecs[3]  = '{32'hFFFF_0000, 1'b1, 6'd16, 1'b0, 6};
        vecs[4]  = '{32'hFFFF_FFFF, 1'b1, 6'd32, 1'b1, 9};
        vecs[5]  = '{32'h7FFF_FFFF, 1'b1, 6'd0,  1'b0, 2};
        vecs[6]  = '{32'h00F0_0000, 1'b0, 6'd8,  1'b0, 4};
        vecs[7]  = '{32'h0000_0001, 1'b0, 6'd31, 1'b0, 9};
        vecs[8]  = '{32'h0000_0002, 1'b0, 6'd30, 1'b0, 9};
        vecs[9]  = '{32'h1000_0000, 1'b0, 6'd3,  1'b0, 2};
        vecs[10] = '{32'h0800_0000, 1'b0, 6'd4,  1'b0, 3};
        vecs[11] = '{32'hFFFF_FFFE, 1'b1, 6'd31, 1'b0, 9};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_ones   = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        #12;
        check("reset in_ready", longint'(in_ready), 1);
        check("reset out_valid", longint'(out_valid), 0);
        check("reset out_count", longint'(out_count), 0);
        check("reset out_all", longint'(out_all), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].data, vecs[i].ones, vecs[i].cnt, vecs[i].all, vecs[i].lat,
                   $sformatf("vec%0d", i));
        end

        // Hold the result for 5 cycles with out_ready low and stray in_valid pulses.
        offer(32'h0001_0000, 1'b0);
        wait_valid(lat);
        check("hold latency", longint'(lat), 5);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            in_data  = 32'h8000_0000;
            @(posedge clk); #1;
            check("hold out_valid", longint'(out_valid), 1);
            check("hold out_count", longint'(out_count), 15);
            check("hold out_all", longint'(out_all), 0);
            check("hold in_ready", longint'(in_ready), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("hold release out_valid", longint'(out_valid), 0);
        check("hold release in_ready", longint'(in_ready), 1);

        // flush in the 2nd SCAN cycle discards the operation.
        offer(32'h0000_0001, 1'b0);
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush in_ready", longint'(in_ready), 1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("flush no out_valid", longint'(out_valid), 0);
        end
        run_op(32'h00F0_0000, 1'b0, 6'd8, 1'b0, 4, "after flush");

        // flush in IDLE beats in_valid.
        in_valid = 1'b1;
        in_data  = 32'h0000_0001;
        flush    = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        check("idle flush no accept", longint'(in_ready), 1);

        // flush in DONE drops out_valid.
        offer(32'h8000_0000, 1'b0);
        wait_valid(lat);
        check("done flush latency", longint'(lat), 2);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("done flush out_valid", longint'(out_valid), 0);
        check("done flush in_ready", longint'(in_ready), 1);

        // Asynchronous reset mid-SCAN, checked before the next clock edge.
        offer(32'h0000_0000, 1'b0);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("async rst in_ready", longint'(in_ready), 1);
        check("async rst out_valid", longint'(out_valid), 0);
        check("async rst out_count", longint'(out_count), 0);
        check("async rst out_all", longint'(out_all), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post rst no out_valid", longint'(out_valid), 0);
        run_op(32'h0000_0001, 1'b0, 6'd31, 1'b0, 9, "post rst a");
        run_op(32'h0000_0002, 1'b0, 6'd30, 1'b0, 9, "post rst b");

        // Random operands against the reference model.
        for (int i = 0; i < 300; i++) begin
            d = 32'($urandom) >> $urandom_range(0, 32);
            o = 1'($urandom);
            if (o) d = ~d;
            n = ref_count(d, o);
            run_op(d, o, 6'(n), (n == 32), ref_lat(n), $sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
